// File: rtl/serial_subtractor_nbit.sv
// serial_subtractor_nbit: bit-serial unsigned a - b, one result bit per clock, LSB first.
// Define SERIAL_SUB_SAT_EN to clamp diff to 0 when a < b (borrow still reports 1).
module serial_subtractor_nbit #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t r_state, w_next;
    logic [N-1:0]  r_a, r_b, r_res, w_res, w_diff_fin;
    logic [CW-1:0] r_cnt;
    logic          r_bor, w_d, w_bout, w_last;
    assign w_d    = r_a[0] ^ r_b[0] ^ r_bor;
    assign w_bout = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bor);
    assign w_res  = {w_d, r_res[N-1:1]};
    assign w_last = r_cnt == CW'(N - 1);
`ifdef SERIAL_SUB_SAT_EN
    assign w_diff_fin = w_bout ? '0 : w_res;
`else
    assign w_diff_fin = w_res;
`endif
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    // Outputs are loaded on the final RUN edge so they are valid as DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_bor  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a   <= a;
            r_b   <= b;
            r_res <= '0;
            r_cnt <= '0;
            r_bor <= 1'b0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res;
            r_bor <= w_bout;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                diff   <= w_diff_fin;
                borrow <= w_bout;
            end
        end
    end
    assign busy = r_state != IDLE;
    assign done = r_state == DONE;
endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// tb_serial_subtractor_nbit: directed scoreboard bench for serial_subtractor_nbit (N=10).
module tb_serial_subtractor_nbit;
    localparam int N = 10;
    logic         clk, rst, start, busy, done, borrow;
    logic [N-1:0] a, b, diff;
    logic [N:0]   sb[$];
    logic [N:0]   exp_v;
    int           n_tests = 0;
    int           n_fail = 0;

    serial_subtractor_nbit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb);
        logic [N:0] r;
        r = {1'b0, ma} - {1'b0, mb};
`ifdef SERIAL_SUB_SAT_EN
        if (r[N]) r[N-1:0] = '0;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_sb"}, 32'(sb.size() > 0), 1);
        if (done && sb.size() > 0) begin
            exp_v = sb.pop_front();
            check({tag, "_diff"}, 32'(diff), 32'(exp_v[N-1:0]));
            check({tag, "_borrow"}, 32'(borrow), 32'(exp_v[N]));
        end
    endtask

    task automatic op(input logic [N-1:0] ta, input logic [N-1:0] tb, input string tag);
        int cyc, busy_n;
        bit stable;
        logic [N-1:0] d0;
        a = ta; b = tb; start = 1'b1;
        sb.push_back(model(ta, tb));
        d0 = diff;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb;
        cyc = 1; busy_n = 32'(busy); stable = 1'b1;
        while (!done && cyc < 40) begin
            if (diff !== d0) stable = 1'b0;
            @(negedge clk);
            cyc++;
            busy_n += 32'(busy);
        end
        check({tag, "_latency"}, 32'(cyc), N + 1);
        check({tag, "_stable"}, 32'(stable), 1);
        check_result(tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 0);
        check({tag, "_idle"}, 32'(busy), 0);
        check({tag, "_busycyc"}, 32'(busy_n), N + 1);
    endtask

    initial begin
        int cyc, dn, last;
        bit prev_busy;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        repeat (2) @(negedge clk);
        check("rst_diff", 32'(diff), 0);
        check("rst_borrow", 32'(borrow), 0);
        rst = 1'b0;
        op(10'd7, 10'd7, "eq7");
        op(10'd100, 10'd47, "100m47");
        op(10'd1023, 10'd0, "max_m0");
        op(10'd33, 10'd66, "33m66");
        op(10'd0, 10'd1023, "0mmax");
        op(10'd512, 10'd511, "512m511");

        // start during RUN must be ignored
        a = 10'd500; b = 10'd1; start = 1'b1;
        sb.push_back(model(10'd500, 10'd1));
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        a = 10'd5; b = 10'd9; start = 1'b1;
        @(negedge clk); start = 1'b0; a = 10'd77; b = 10'd300;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_result("ign");
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            dn += 32'(done);
        end
        check("ign_no_second", 32'(dn), 0);
        check("ign_idle", 32'(busy), 0);

        // asynchronous reset mid-RUN
        a = 10'd200; b = 10'd100; start = 1'b1;
        sb.push_back(model(10'd200, 10'd100));
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_diff", 32'(diff), 0);
        check("abort_borrow", 32'(borrow), 0);
        sb.delete();
        @(negedge clk); rst = 1'b0;
        dn = 0;
        repeat (15) begin
            @(negedge clk);
            dn += 32'(done);
        end
        check("abort_no_done", 32'(dn), 0);
        op(10'd200, 10'd100, "after_abort");

        // start held high: back-to-back operations
        a = 10'd1023; b = 10'd1023; start = 1'b1;
        sb.push_back(model(10'd1023, 10'd1023));
        prev_busy = 1'b1;
        cyc = 0; dn = 0; last = -1;
        while (dn < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) sb.push_back(model(10'd1023, 10'd1023));
            prev_busy = busy;
            if (done) begin
                check_result("hold");
                if (last >= 0) check("hold_period", 32'(cyc - last), 12);
                last = cyc;
                dn++;
            end
        end
        check("hold_count", 32'(dn), 3);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("hold_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
